// File: rtl/img_stream_pkg.sv
// Shared types and defaults for the greyscale pixel streaming path.
// Used by the frame streamer, its skid buffer and the edge-filter output stage.
package img_stream_pkg;

    localparam int DEF_PIXEL_W = 8;
    localparam int DEF_ROWS    = 242;
    localparam int DEF_COLS    = 247;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FIN
    } streamer_state_t;

    typedef struct packed {
        logic [DEF_PIXEL_W-1:0] data;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } pix_beat_t;

    // Index width that stays legal (>= 1 bit) for degenerate 1-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Purpose: 2-entry buffer of pixel beats between a 1-cycle read pipe and a valid/ready stream.
// Latency: a push is visible at head on the cycle after it; head is read straight from storage.
// Backpressure: a push into a full buffer without a same-cycle pop is discarded; callers reserve space.
module pixel_skid_fifo
    import img_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  pix_beat_t  push_beat,
    input  logic       pop,
    output pix_beat_t  head,
    output logic [1:0] count
);

    pix_beat_t slot [2];
    logic      wr_ptr;
    logic      rd_ptr;
    logic      do_push;
    logic      do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_beat;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Purpose: raster-order source reading a ROWS x COLS frame buffer onto a stream with sof/eol/eof markers.
// Latency: first m_valid two edges after the start-accepting edge; then 1 pixel/clk while m_ready=1.
// Backpressure: reads issue only while buffer plus in-flight room remains, so stalls never drop beats.
// Build option PIXEL_TEST_PATTERN_EN adds test_mode, streaming (row+col) instead of memory data.
module frame_pixel_streamer
    import img_stream_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int PIXEL_W = DEF_PIXEL_W,
    parameter int ADDR_W  = idx_width(ROWS * COLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef PIXEL_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIXEL_W-1:0] mem_rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PIXEL_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof
);

    localparam int ROW_W = idx_width(ROWS);
    localparam int COL_W = idx_width(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    streamer_state_t   state;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [ADDR_W-1:0] rd_addr;
    logic              inf_vld;
    pix_beat_t         inf_beat;
    pix_beat_t         push_beat;
    pix_beat_t         head;
    logic [1:0]        fifo_count;
    logic [2:0]        load;
    logic              issue;
    logic              pop;
    logic              last_pix;
    logic              drained;
`ifdef PIXEL_TEST_PATTERN_EN
    logic              test_q;
`endif

    assign m_valid  = (fifo_count != 2'd0);
    assign pop      = m_valid && m_ready;
    // Slots still claimed once this cycle's pop retires; counting the pop keeps 1 pixel/clk.
    assign load     = 3'(fifo_count) + 3'(inf_vld) - 3'(pop);
    assign issue    = (state == FETCH) && (load < 3'd2);
    assign last_pix = (rd_row == ROW_LAST) && (rd_col == COL_LAST);
    assign drained  = !inf_vld && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

`ifdef PIXEL_TEST_PATTERN_EN
    assign mem_rd_en = issue && !test_q;
`else
    assign mem_rd_en = issue;
`endif
    assign mem_addr = rd_addr;

    always_comb begin
        push_beat = inf_beat;
`ifdef PIXEL_TEST_PATTERN_EN
        if (!test_q) begin
            push_beat.data = DEF_PIXEL_W'(mem_rd_data);
        end
`else
        push_beat.data = DEF_PIXEL_W'(mem_rd_data);
`endif
    end

    pixel_skid_fifo u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inf_vld),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign m_data = m_valid ? PIXEL_W'(head.data) : '0;
    assign m_sof  = m_valid && head.sof;
    assign m_eol  = m_valid && head.eol;
    assign m_eof  = m_valid && head.eof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_row   <= '0;
            rd_col   <= '0;
            rd_addr  <= '0;
            inf_vld  <= 1'b0;
            inf_beat <= '0;
`ifdef PIXEL_TEST_PATTERN_EN
            test_q   <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            inf_vld <= issue;
            // Markers are fixed at issue time and ride alongside the read to the buffer.
            if (issue) begin
                inf_beat.sof <= (rd_row == '0) && (rd_col == '0);
                inf_beat.eol <= (rd_col == COL_LAST);
                inf_beat.eof <= last_pix;
`ifdef PIXEL_TEST_PATTERN_EN
                inf_beat.data <= DEF_PIXEL_W'(rd_row) + DEF_PIXEL_W'(rd_col);
`endif
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        rd_row  <= '0;
                        rd_col  <= '0;
                        rd_addr <= '0;
`ifdef PIXEL_TEST_PATTERN_EN
                        test_q  <= test_mode;
`endif
                    end
                end
                FETCH: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (rd_col == COL_LAST) begin
                            rd_col <= '0;
                            rd_row <= rd_row + ROW_W'(1);
                        end else begin
                            rd_col <= rd_col + COL_W'(1);
                        end
                        if (last_pix) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer: a 3x4 instance with a synchronous memory model and a 1x1 instance.
// Expected beats come from raster-order arithmetic over the stored frame.
module tb_frame_pixel_streamer;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int NPIX = ROWS * COLS;
    localparam int PW = 8;
    localparam int AW = 4;
    localparam int FRAME_BUDGET = 400;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic          start_a = 1'b0, ready_a = 1'b0;
    logic          busy_a, done_a, rd_en_a, valid_a, sof_a, eol_a, eof_a;
    logic [AW-1:0] addr_a;
    logic [PW-1:0] rdata_a = '0, data_a;
    logic [PW-1:0] mem_a [NPIX];

    logic          start_b = 1'b0, ready_b = 1'b0;
    logic          busy_b, done_b, rd_en_b, valid_b, sof_b, eol_b, eof_b;
    logic [0:0]    addr_b;
    logic [PW-1:0] rdata_b = '0, data_b, mem_b = '0;
`ifdef PIXEL_TEST_PATTERN_EN
    logic          test_a = 1'b0, test_b = 1'b0;
`endif

    frame_pixel_streamer #(.ROWS(ROWS), .COLS(COLS), .PIXEL_W(PW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef PIXEL_TEST_PATTERN_EN
        .test_mode(test_a),
`endif
        .busy(busy_a), .done(done_a), .mem_rd_en(rd_en_a), .mem_addr(addr_a),
        .mem_rd_data(rdata_a), .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a),
        .m_sof(sof_a), .m_eol(eol_a), .m_eof(eof_a)
    );

    frame_pixel_streamer #(.ROWS(1), .COLS(1), .PIXEL_W(PW)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef PIXEL_TEST_PATTERN_EN
        .test_mode(test_b),
`endif
        .busy(busy_b), .done(done_b), .mem_rd_en(rd_en_b), .mem_addr(addr_b),
        .mem_rd_data(rdata_b), .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b),
        .m_sof(sof_b), .m_eol(eol_b), .m_eof(eof_b)
    );

    // Synchronous frame-buffer read ports: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en_a) rdata_a <= (int'(addr_a) < NPIX) ? mem_a[addr_a] : 'x;
        if (rd_en_b) rdata_b <= (addr_b == 1'b0) ? mem_b : 'x;
    end

    // Stream monitor for the 3x4 instance, sampled mid-cycle.
    beat_t got_q[$];
    int    got_cyc[$];
    int    done_cyc[$];
    int    cyc = 0;
    int    frm_issued = 0, frm_popped = 0, start_cyc = 0, first_valid = -1;
    int    credit_err = 0, addr_err = 0, stab_err = 0, rd_total = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat, cur_beat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cur_beat = {data_a, sof_a, eol_a, eof_a};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (start_a && !busy_a && !done_a) begin
                frm_issued = 0;
                frm_popped = 0;
                start_cyc = cyc;
                first_valid = -1;
            end
            if (rd_en_a) begin
                rd_total++;
                // Pixels read but not yet accepted, after this cycle's accept, must leave room.
                if (frm_issued - frm_popped - int'(valid_a && ready_a) >= 2) credit_err++;
                if (int'(addr_a) != frm_issued) addr_err++;
                frm_issued++;
            end
            if (prev_stall && (!valid_a || cur_beat !== prev_beat)) stab_err++;
            prev_stall = valid_a && !ready_a;
            prev_beat = cur_beat;
            if (valid_a && first_valid < 0) first_valid = cyc;
            if (valid_a && ready_a) begin
                got_q.push_back(cur_beat);
                got_cyc.push_back(cyc);
                frm_popped++;
            end
            if (done_a) done_cyc.push_back(cyc);
        end
    end

    beat_t exp_beats [NPIX];

    task automatic build_expected(input bit pattern);
        for (int i = 0; i < NPIX; i++) begin
            exp_beats[i].data = pattern ? PW'((i / COLS) + (i % COLS)) : mem_a[i];
            exp_beats[i].sof  = (i == 0);
            exp_beats[i].eol  = ((i % COLS) == COLS - 1);
            exp_beats[i].eof  = (i == NPIX - 1);
        end
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < NPIX; i++) mem_a[i] = ramp ? PW'(i) : PW'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, else random ready.
    task automatic stream(input int mode, input int restart_beat, output bit timed_out);
        int base_done;
        int base_got;
        bit restarted;
        base_done = done_cyc.size();
        base_got = got_q.size();
        restarted = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < FRAME_BUDGET; k++) begin
            case (mode)
                0: ready_a = 1'b1;
                1: ready_a = ((k % 4) == 0) || ((k % 4) == 3);
                default: ready_a = ($urandom_range(0, 2) != 0);
            endcase
            if (!restarted && restart_beat >= 0 && got_q.size() - base_got == restart_beat) begin
                start_a = 1'b1;
                restarted = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            tick();
            if (done_cyc.size() > base_done) begin
                timed_out = 1'b0;
                break;
            end
        end
        start_a = 1'b0;
        ready_a = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, rd_en_a, valid_a, sof_a, eol_a, eof_a} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl_a got=%b exp=0", {busy_a, done_a, rd_en_a, valid_a, sof_a, eol_a, eof_a});
        end
        checks++;
        if (data_a !== '0 || addr_a !== '0) begin
            failures++;
            $display("FAIL reset_bus_a data=%h addr=%h exp=0", data_a, addr_a);
        end
        checks++;
        if ({busy_b, done_b, rd_en_b, valid_b, sof_b, eol_b, eof_b, addr_b} !== 8'b0 || data_b !== '0) begin
            failures++;
            $display("FAIL reset_b got=%b data=%h exp=0", {busy_b, done_b, rd_en_b, valid_b, sof_b, eol_b, eof_b}, data_b);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame(input bit pattern);
        int base, base_done, base_rd;
        bit to;
        base = got_q.size();
        base_done = done_cyc.size();
        base_rd = rd_total;
        build_expected(pattern);
        pulse_start();
        stream(0, -1, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout pattern=%0d no done within %0d cycles", pattern, FRAME_BUDGET); end
        checks++;
        if (got_q.size() - base != NPIX) begin
            failures++;
            $display("FAIL basic_count pattern=%0d got=%0d exp=%0d", pattern, got_q.size() - base, NPIX);
        end
        for (int i = 0; i < NPIX && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_beats[i]) begin
                failures++;
                $display("FAIL basic_beat%0d pattern=%0d got=%h exp=%h", i, pattern, got_q[base + i], exp_beats[i]);
            end
        end
        if (got_q.size() - base == NPIX && done_cyc.size() > base_done) begin
            checks++;
            if (first_valid - start_cyc != 3) begin
                failures++;
                $display("FAIL first_valid_latency got=%0d exp=3 (start cycle to first valid cycle)", first_valid - start_cyc);
            end
            checks++;
            if (got_cyc[base + NPIX - 1] - got_cyc[base] != NPIX - 1) begin
                failures++;
                $display("FAIL throughput_span got=%0d exp=%0d", got_cyc[base + NPIX - 1] - got_cyc[base], NPIX - 1);
            end
            checks++;
            if (done_cyc[base_done] - got_cyc[base + NPIX - 1] != 1) begin
                failures++;
                $display("FAIL done_timing got=%0d exp=1", done_cyc[base_done] - got_cyc[base + NPIX - 1]);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", busy_a); end
        checks++;
        if (rd_total - base_rd != (pattern ? 0 : NPIX)) begin
            failures++;
            $display("FAIL read_count pattern=%0d got=%0d exp=%0d", pattern, rd_total - base_rd, pattern ? 0 : NPIX);
        end
    endtask

    task automatic test_backpressure(input int mode, input int frames);
        int base, se, ce, ae;
        bit to;
        se = stab_err;
        ce = credit_err;
        ae = addr_err;
        for (int f = 0; f < frames; f++) begin
            fill_mem(1'b0);
            build_expected(1'b0);
            base = got_q.size();
            pulse_start();
            stream(mode, -1, to);
            checks++;
            if (to) begin failures++; $display("FAIL bp_timeout mode=%0d frame=%0d", mode, f); end
            checks++;
            if (got_q.size() - base != NPIX) begin
                failures++;
                $display("FAIL bp_count mode=%0d got=%0d exp=%0d", mode, got_q.size() - base, NPIX);
            end
            for (int i = 0; i < NPIX && base + i < got_q.size(); i++) begin
                checks++;
                if (got_q[base + i] !== exp_beats[i]) begin
                    failures++;
                    $display("FAIL bp_beat%0d mode=%0d got=%h exp=%h", i, mode, got_q[base + i], exp_beats[i]);
                end
            end
        end
        checks++;
        if (stab_err != se) begin failures++; $display("FAIL stall_stability mode=%0d violations=%0d exp=0", mode, stab_err - se); end
        checks++;
        if (credit_err != ce) begin failures++; $display("FAIL credit mode=%0d violations=%0d exp=0", mode, credit_err - ce); end
        checks++;
        if (addr_err != ae) begin failures++; $display("FAIL address_seq mode=%0d violations=%0d exp=0", mode, addr_err - ae); end
    endtask

    task automatic test_reset_abort();
        int base, base_done;
        bit to;
        fill_mem(1'b0);
        base = got_q.size();
        pulse_start();
        ready_a = 1'b1;
        for (int k = 0; k < 50 && got_q.size() - base < 6; k++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, rd_en_a, valid_a, sof_a, eol_a, eof_a} !== 7'b0 || data_a !== '0 || addr_a !== '0) begin
            failures++;
            $display("FAIL abort_outputs ctrl=%b data=%h addr=%h exp=0", {busy_a, done_a, rd_en_a, valid_a, sof_a, eol_a, eof_a}, data_a, addr_a);
        end
        ready_a = 1'b0;
        base_done = done_cyc.size();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (done_cyc.size() != base_done) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cyc.size() - base_done); end
        build_expected(1'b0);
        base = got_q.size();
        pulse_start();
        stream(0, -1, to);
        checks++;
        if (to || got_q.size() - base != NPIX) begin
            failures++;
            $display("FAIL abort_restart_count got=%0d exp=%0d timeout=%0d", got_q.size() - base, NPIX, to);
        end
        for (int i = 0; i < NPIX && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_beats[i]) begin
                failures++;
                $display("FAIL abort_restart_beat%0d got=%h exp=%h", i, got_q[base + i], exp_beats[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int base, base_done;
        bit to;
        fill_mem(1'b0);
        build_expected(1'b0);
        base = got_q.size();
        base_done = done_cyc.size();
        pulse_start();
        stream(0, 4, to);
        repeat (8) tick();
        checks++;
        if (done_cyc.size() - base_done != 1) begin
            failures++;
            $display("FAIL restart_done_count got=%0d exp=1", done_cyc.size() - base_done);
        end
        checks++;
        if (got_q.size() - base != NPIX) begin
            failures++;
            $display("FAIL restart_beat_count got=%0d exp=%0d", got_q.size() - base, NPIX);
        end
        for (int i = 0; i < NPIX && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_beats[i]) begin
                failures++;
                $display("FAIL restart_beat%0d got=%h exp=%h", i, got_q[base + i], exp_beats[i]);
            end
        end
    endtask

    task automatic test_single_pixel();
        logic [PW-1:0] v;
        int wait_k;
        for (int f = 0; f < 2; f++) begin
            v = (f == 0) ? 8'hA5 : PW'($urandom);
            mem_b = v;
            ready_b = 1'b1;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            wait_k = -1;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (valid_b) begin
                    wait_k = k;
                    break;
                end
            end
            checks++;
            if (wait_k != 1) begin failures++; $display("FAIL one_latency frame=%0d got=%0d exp=1", f, wait_k); end
            checks++;
            if (data_b !== v || {sof_b, eol_b, eof_b} !== 3'b111) begin
                failures++;
                $display("FAIL one_beat frame=%0d data=%h markers=%b exp data=%h markers=111", f, data_b, {sof_b, eol_b, eof_b}, v);
            end
            tick();
            checks++;
            if (done_b !== 1'b1 || valid_b !== 1'b0) begin
                failures++;
                $display("FAIL one_done frame=%0d done=%b valid=%b exp done=1 valid=0", f, done_b, valid_b);
            end
            tick();
            ready_b = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        fill_mem(1'b1);
        test_basic_frame(1'b0);
        test_backpressure(1, 1);
        test_backpressure(2, 3);
        test_reset_abort();
        test_restart_ignored();
        test_single_pixel();
`ifdef PIXEL_TEST_PATTERN_EN
        test_a = 1'b1;
        test_basic_frame(1'b1);
        test_a = 1'b0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
